// File: rtl/unidade_desvio_pkg.sv
// Shared types for the branch-resolution stage: request kinds, condition codes,
// FSM states and the bit positions of the ZCSO flags.
package pacote_desvio;

    typedef enum logic [1:0] {
        NOP      = 2'b00,
        INCOND   = 2'b01,
        SE_VERD  = 2'b10,
        SE_FALSO = 2'b11
    } tipo_t;

    typedef enum logic [2:0] {
        C_SEMPRE   = 3'b000,
        C_S        = 3'b001,
        C_Z        = 3'b010,
        C_C        = 3'b011,
        C_SZ       = 3'b100,
        C_O        = 3'b101,
        C_MENOR    = 3'b110,
        C_MAIOR_IG = 3'b111
    } cond_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } estado_t;

    localparam int unsigned BIT_Z = 0;
    localparam int unsigned BIT_C = 1;
    localparam int unsigned BIT_S = 2;
    localparam int unsigned BIT_O = 3;

endpackage

// File: rtl/unidade_desvio_avaliador.sv
// Combinational condition evaluator: maps a condition code and the ZCSO flags
// to a single true/false result. Shared with future conditional-move logic.
module avaliador_condicao
    import pacote_desvio::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] ZCSO,
    output logic       c
);

    logic z, cy, s, o;

    always_comb begin
        z  = ZCSO[BIT_Z];
        cy = ZCSO[BIT_C];
        s  = ZCSO[BIT_S];
        o  = ZCSO[BIT_O];
        c  = 1'b0;
        case (cond_t'(cond))
            C_SEMPRE:   c = 1'b1;
            C_S:        c = s;
            C_Z:        c = z;
            C_C:        c = cy;
            C_SZ:       c = s | z;
            C_O:        c = o;
            C_MENOR:    c = s ^ o;
            C_MAIOR_IG: c = ~(s ^ o);
            default:    c = 1'b0;
        endcase
    end

endmodule

// File: rtl/unidade_desvio.sv
// Branch-resolution stage: evaluates a decoded branch against the registered
// flags, pulses pc_load with the target, then holds a fixed-length flush.
module unidade_desvio
    import pacote_desvio::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [1:0]       tipo,
    input  logic [2:0]       cond,
    input  logic [3:0]       ZCSO,
    input  logic [WIDTH-1:0] alvo,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_alvo,
    output logic             flush,
    output logic [15:0]      contador_desvios
);

    localparam logic [2:0] RESTANTE_INI = 3'(FLUSH_CYCLES);

    estado_t    estado, estado_n;
    logic [2:0] restante, restante_n;
    logic       c, aceito, tomado;
    logic [15:0] cont_q;

    avaliador_condicao u_avaliador (
        .cond (cond),
        .ZCSO (ZCSO),
        .c    (c)
    );

    assign ready_in         = (estado == IDLE);
    assign flush            = (estado == FLUSH);
    assign aceito           = valid_in & ready_in;
    assign contador_desvios = cont_q;

    always_comb begin
        tomado = 1'b0;
        case (tipo_t'(tipo))
            INCOND:   tomado = 1'b1;
            SE_VERD:  tomado = c;
            SE_FALSO: tomado = ~c;
            default:  tomado = 1'b0;
        endcase
    end

    always_comb begin
        estado_n   = estado;
        restante_n = restante;
        case (estado)
            IDLE: begin
                if (aceito && tomado) begin
                    estado_n   = FLUSH;
                    restante_n = RESTANTE_INI;
                end
            end
            FLUSH: begin
                restante_n = restante - 3'd1;
                if (restante == 3'd1) begin
                    estado_n = IDLE;
                end
            end
            default: estado_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= IDLE;
            restante <= '0;
            pc_load  <= 1'b0;
            pc_alvo  <= '0;
            cont_q   <= '0;
        end else begin
            estado   <= estado_n;
            restante <= restante_n;
            pc_load  <= aceito & tomado;
            if (aceito && tomado) begin
                pc_alvo <= alvo;
                if (cont_q != 16'hFFFF) begin
                    cont_q <= cont_q + 16'd1;
                end
            end
        end
    end

endmodule
